// File: rtl/opcode_sequencer.sv
// Group-1 (opcode[1:0]=01) decode/sequence engine: fetches operand/pointer bytes, forms the EA, emits one execute packet.
// Latency 2..5 cycles accept->EXEC; EXEC holds while exec_ready=0, and op_ready is high only in IDLE.
module opcode_sequencer #(
  parameter int          REG_WIDTH      = 8,
  parameter int          ADDR_WIDTH     = 16,
  parameter int unsigned STA_FIX_ALWAYS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [REG_WIDTH-1:0]  opcode,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [2:0]            alu_op,
  output logic                  is_imm,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [1:0]            pc_inc,
  output logic                  page_cross,
  output logic                  illegal
);

  localparam int ZW = ADDR_WIDTH - REG_WIDTH;

  localparam logic [2:0] M_IZX = 3'd0;
  localparam logic [2:0] M_ZP  = 3'd1;
  localparam logic [2:0] M_IMM = 3'd2;
  localparam logic [2:0] M_ABS = 3'd3;
  localparam logic [2:0] M_IZY = 3'd4;
  localparam logic [2:0] M_ZPX = 3'd5;
  localparam logic [2:0] M_ABY = 3'd6;
  localparam logic [2:0] M_ABX = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_OPND_LO, S_OPND_HI, S_INDEX, S_PTR_LO, S_PTR_HI, S_FIX, S_EXEC, S_ILL
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_alu;
  logic [2:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [REG_WIDTH-1:0]  r_x;
  logic [REG_WIDTH-1:0]  r_y;
  logic [REG_WIDTH-1:0]  r_lo;
  logic [REG_WIDTH-1:0]  r_hi;
  logic [REG_WIDTH-1:0]  r_ptr;

  logic                  w_illegal_in;
  logic                  w_sta;
  logic [REG_WIDTH-1:0]  w_idx;
  logic [REG_WIDTH-1:0]  w_base_hi;
  logic [REG_WIDTH:0]    w_low_sum;
  logic                  w_carry;
  logic [ADDR_WIDTH-1:0] w_sum;
  logic                  w_need_fix;
  logic [REG_WIDTH-1:0]  w_zpx;
  logic                  w_load_pkt;
  logic [ADDR_WIDTH-1:0] w_pkt_ea;
  logic                  w_pkt_pc;
  logic                  w_indexed;

  assign w_illegal_in = (opcode[1:0] != 2'b01) || (opcode == REG_WIDTH'(8'h89));
  assign w_sta        = (r_alu == 3'b100);
  assign w_idx        = (r_mode == M_ABX) ? r_x : r_y;
  // High base byte arrives on the bus in OPND_HI/PTR_HI, and is held in r_hi by FIX.
  assign w_base_hi    = (r_state == S_FIX) ? r_hi : mem_rdata;
  assign w_low_sum    = {1'b0, r_lo} + {1'b0, w_idx};
  assign w_carry      = w_low_sum[REG_WIDTH];
  assign w_sum        = {w_base_hi, r_lo} + {{ZW{1'b0}}, w_idx};
  assign w_need_fix   = w_carry || ((STA_FIX_ALWAYS != 0) && w_sta);
  assign w_zpx        = r_lo + r_x;
  assign w_indexed    = (r_mode == M_IZY) || (r_mode == M_ABY) || (r_mode == M_ABX);
  assign w_load_pkt   = (w_next == S_EXEC) && (r_state != S_EXEC);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (op_valid) w_next = w_illegal_in ? S_ILL : S_OPND_LO;
      S_OPND_LO: begin
        case (r_mode)
          M_IMM, M_ZP:  w_next = S_EXEC;
          M_ZPX, M_IZX: w_next = S_INDEX;
          M_IZY:        w_next = S_PTR_LO;
          default:      w_next = S_OPND_HI;
        endcase
      end
      S_OPND_HI: w_next = ((r_mode != M_ABS) && w_need_fix) ? S_FIX : S_EXEC;
      S_INDEX:   w_next = (r_mode == M_IZX) ? S_PTR_LO : S_EXEC;
      S_PTR_LO:  w_next = S_PTR_HI;
      S_PTR_HI:  w_next = ((r_mode == M_IZY) && w_need_fix) ? S_FIX : S_EXEC;
      S_FIX:     w_next = S_EXEC;
      S_EXEC:    w_next = exec_ready ? S_IDLE : S_EXEC;
      S_ILL:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready   = (r_state == S_IDLE);
    exec_valid = (r_state == S_EXEC);
    illegal    = (r_state == S_ILL);
    mem_rd     = 1'b0;
    mem_addr   = '0;
    case (r_state)
      S_OPND_LO: begin mem_rd = 1'b1; mem_addr = r_pc; end
      S_OPND_HI: begin mem_rd = 1'b1; mem_addr = r_pc + ADDR_WIDTH'(1); end
      S_PTR_LO:  begin mem_rd = 1'b1; mem_addr = {{ZW{1'b0}}, r_ptr}; end
      S_PTR_HI:  begin mem_rd = 1'b1; mem_addr = {{ZW{1'b0}}, r_ptr + REG_WIDTH'(1)}; end
      default:   ;
    endcase
  end

  always_comb begin
    w_pkt_pc = 1'b0;
    case (r_mode)
      M_IMM:        w_pkt_ea = r_pc;
      M_ZP:         w_pkt_ea = {{ZW{1'b0}}, mem_rdata};
      M_ZPX:        w_pkt_ea = {{ZW{1'b0}}, w_zpx};
      M_ABS, M_IZX: w_pkt_ea = {mem_rdata, r_lo};
      default: begin
        w_pkt_ea = w_sum;
        w_pkt_pc = w_carry;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_alu      <= '0;
      r_mode     <= '0;
      r_pc       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_ptr      <= '0;
      alu_op     <= '0;
      is_imm     <= 1'b0;
      operand    <= '0;
      ea         <= '0;
      pc_inc     <= '0;
      page_cross <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_alu  <= opcode[7:5];
            r_mode <= opcode[4:2];
            r_pc   <= pc;
            r_x    <= x_in;
            r_y    <= y_in;
          end
        end
        S_OPND_LO: begin
          r_lo  <= mem_rdata;
          r_ptr <= mem_rdata;
        end
        S_OPND_HI, S_PTR_HI: r_hi <= mem_rdata;
        S_INDEX:             r_ptr <= w_zpx;
        S_PTR_LO:            r_lo <= mem_rdata;
        default:             ;
      endcase
      // Packet only changes on entry to EXEC so it stays put between instructions.
      if (w_load_pkt) begin
        alu_op     <= r_alu;
        is_imm     <= (r_mode == M_IMM);
        operand    <= (r_mode == M_IMM) ? mem_rdata : '0;
        ea         <= w_pkt_ea;
        pc_inc     <= ((r_mode == M_ABS) || (r_mode == M_ABY) || (r_mode == M_ABX)) ? 2'd2 : 2'd1;
        page_cross <= w_indexed && w_pkt_pc;
      end
    end
  end

endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Multi-cycle decode/sequence engine for the CPU's group-1 instructions: opcode[1:0]=01, i.e. ORA AND EOR ADC STA LDA CMP SBC.
- Covers all eight group-1 addressing modes. Fetches operand and pointer bytes from memory, computes the effective address with index and zero-page wrap, then presents one execute packet to the datapath under a ready/valid handshake.
- Sits between the fetch unit, which supplies opcodes, and the ALU/register-select logic. Any other opcode is flagged illegal.

Parameters:
- REG_WIDTH, 8, data byte width; zero page = addresses < 2^REG_WIDTH.
- ADDR_WIDTH, 16, address width; must equal 2*REG_WIDTH.
- STA_FIX_ALWAYS, 1, when 1 STA in abs,X / abs,Y / (zp),Y always spends the FIX cycle.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- op_valid  in  1  opcode offered
- op_ready  out  1  high only in IDLE
- opcode  in  REG_WIDTH  instruction byte
- pc  in  ADDR_WIDTH  address of first operand byte
- x_in, y_in  in  REG_WIDTH  index registers
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  REG_WIDTH  read data, combinational, valid in same cycle as mem_rd
- exec_valid  out  1  execute packet valid
- exec_ready  in  1  datapath accepts packet
- alu_op  out  3  opcode[7:5]
- is_imm  out  1  operand is immediate
- operand  out  REG_WIDTH  immediate byte
- ea  out  ADDR_WIDTH  effective address
- pc_inc  out  2  operand bytes consumed (1 or 2)
- page_cross  out  1  index carry into high byte
- illegal  out  1  one-cycle pulse

Behaviour:
- Reset (reset_n=0 at posedge):
  - state<=IDLE.
  - exec_valid, mem_rd, illegal, alu_op, is_imm, operand, ea, pc_inc, page_cross all <=0.
  - op_ready=1 from the first cycle after release.
- Reset mid-sequence: abandon the instruction; no exec_valid and no illegal.
- Accept: op_valid&&op_ready at a posedge latches opcode, pc, x_in and y_in. Inputs are ignored thereafter until the next IDLE.
- Mode: mode = opcode[4:2].
  - 0 (zp,X)
  - 1 zp
  - 2 imm
  - 3 abs
  - 4 (zp),Y
  - 5 zp,X
  - 6 abs,Y
  - 7 abs,X
- Illegal: opcode[1:0]!=01, or STA imm (0x89).
  - Next state ILL: illegal=1 for one cycle, then IDLE.
  - No mem_rd and no exec_valid.
- States: IDLE, OPND_LO, OPND_HI, INDEX, PTR_LO, PTR_HI, FIX, EXEC, ILL. Each non-IDLE state lasts exactly one cycle except EXEC.
- Reads:
  - OPND_LO reads pc; OPND_HI reads pc+1.
  - PTR_LO reads {0, p}; PTR_HI reads {0, (p+1) mod 2^REG_WIDTH}.
  - p = lo+X (mode 0) or lo (mode 4), mod 2^REG_WIDTH.
  - mem_rd=1 only in these states; mem_addr=0 otherwise.
- Sequences (cycles after accept edge, to the first EXEC cycle):
  - imm: OPND_LO -> EXEC, 2.
  - zp: OPND_LO -> EXEC, 2.
  - zp,X: OPND_LO -> INDEX -> EXEC, 3.
  - abs: OPND_LO -> OPND_HI -> EXEC, 3.
  - abs,X/Y: OPND_LO -> OPND_HI -> [FIX] -> EXEC, 3 or 4.
  - (zp),Y: OPND_LO -> PTR_LO -> PTR_HI -> [FIX] -> EXEC, 4 or 5.
  - (zp,X): OPND_LO -> INDEX -> PTR_LO -> PTR_HI -> EXEC, 5.
- FIX is entered when base low byte + index >= 2^REG_WIDTH. When STA_FIX_ALWAYS=1, STA enters FIX in these modes regardless.
- Effective address:
  - zp: {0, lo}.
  - zp,X: {0, (lo+X) mod 2^REG_WIDTH}. Never crosses into page 1.
  - abs: {hi, lo}.
  - abs,X/Y and (zp),Y: (base + index) mod 2^ADDR_WIDTH.
  - page_cross=1 iff the low-byte add carried.
  - imm: ea=pc, operand=mem byte, is_imm=1.
- pc_inc: 2 for modes 3, 6, 7; 1 otherwise.
- EXEC:
  - exec_valid=1 with all packet fields stable.
  - Stays in EXEC while exec_ready=0.
  - At the edge with exec_ready=1, go to IDLE and exec_valid<=0.
  - op_ready stays 0 until IDLE, so the next accept is at the earliest 1 cycle after the handshake.
- Packet fields hold their values after exec until the next EXEC.

Test Plan:
- Reset then LDA imm: 0xA9, pc=0x0200, mem[0x0200]=0x42, exec_ready=1.
  - exec_valid 2 cycles after accept, alu_op=5, is_imm=1, operand=0x42, pc_inc=1.
- zp,X wrap: ADC 0x75, mem[pc]=0xF0, X=0x20.
  - ea=0x0010, 3-cycle latency, page_cross=0.
- abs,X page cross: LDA 0xBD, operand 0x12FF, X=0x01.
  - ea=0x1300, page_cross=1, latency 4.
  - Same with X=0x00: ea=0x12FF, latency 3.
  - STA 0x9D with X=0x00: latency 4 (STA_FIX_ALWAYS).
- Pointer modes, zero-page wrap:
  - (zp,X) 0x01: lo=0xFE, X=0x01 -> reads 0x00FF then 0x0000; mem={0x34,0x12} -> ea=0x1234, latency 5.
  - (zp),Y 0x11: lo=0xFF, mem[0xFF]=0xF0, mem[0x00]=0x20, Y=0x20 -> ea=0x2110, page_cross=1, latency 5.
- Illegal and stall:
  - 0x89, then 0x02 -> each gives a single illegal pulse, no mem_rd, op_ready back after 2 cycles.
  - exec_ready held 0 for 5 cycles -> exec_valid and packet stable for 5 cycles, op_ready=0 throughout.
- Reset mid-sequence: reset_n=0 during PTR_LO of (zp,X).
  - No exec_valid; op_ready=1 the cycle after release.
  - Next LDA imm completes normally.
